// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer (start detect, bit timing, LSB-first deserialise, parity/stop check); parity checking enabled by UART_RX_PAR_CHK_EN
module uart_rx_ctrl #(
  parameter int PRESCALE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic       par_typ,
  input  logic [3:0] bit_count,
  output logic       bit_cnt_en,
  output logic       edge_done,
  output logic       par_en_lat,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       par_err,
  output logic       stop_err,
  output logic       busy
);
  localparam int W = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);
  localparam logic [W-1:0] MID = W'(PRESCALE / 2);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] edge_cnt_q, edge_cnt_d;
  logic [7:0] shreg_q, shreg_d, data_out_q, data_out_d;
  logic par_en_lat_q, par_en_lat_d, par_flag_q, par_flag_d, stop_flag_q, stop_flag_d;
  logic data_valid_q, data_valid_d, par_err_q, par_err_d, stop_err_q, stop_err_d;
  logic tick, par_bad;
`ifdef UART_RX_PAR_CHK_EN
  assign par_bad = ^shreg_q ^ rx_in ^ par_typ;
`else
  logic unused_par_typ;
  assign unused_par_typ = par_typ;
  assign par_bad = 1'b0;
`endif
  assign busy = state_q != IDLE;
  assign bit_cnt_en = busy && state_q != DONE;
  assign tick = edge_cnt_q == MID;
  assign edge_done = bit_cnt_en && edge_cnt_q == LAST;
  assign par_en_lat = par_en_lat_q;
  assign data_out = data_out_q;
  assign data_valid = data_valid_q;
  assign par_err = par_err_q;
  assign stop_err = stop_err_q;
  always_comb begin
    state_d = state_q;
    edge_cnt_d = bit_cnt_en ? (edge_done ? '0 : edge_cnt_q + 1'b1) : '0;
    shreg_d = shreg_q;
    data_out_d = data_out_q;
    par_en_lat_d = par_en_lat_q;
    par_flag_d = par_flag_q;
    stop_flag_d = stop_flag_q;
    data_valid_d = 1'b0;
    par_err_d = 1'b0;
    stop_err_d = 1'b0;
    case (state_q)
      IDLE: if (!rx_in) begin
        state_d = START;
        edge_cnt_d = W'(1);
        par_en_lat_d = par_en;
        par_flag_d = 1'b0;
        stop_flag_d = 1'b0;
      end
      START: begin
        if (tick && rx_in) begin
          state_d = IDLE;
          edge_cnt_d = '0;
        end else if (edge_done) state_d = DATA;
      end
      DATA: begin
        if (tick) shreg_d = {rx_in, shreg_q[7:1]};
        if (edge_done && bit_count == 4'd8) state_d = par_en_lat_q ? PARITY : STOP;
      end
      PARITY: begin
        if (tick) par_flag_d = par_bad;
        if (edge_done) state_d = STOP;
      end
      STOP: begin
        if (tick) stop_flag_d = !rx_in;
        if (edge_done) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        data_valid_d = !par_flag_q && !stop_flag_q;
        data_out_d = data_valid_d ? shreg_q : data_out_q;
        par_err_d = par_flag_q;
        stop_err_d = stop_flag_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      edge_cnt_q <= '0;
      shreg_q <= '0;
      data_out_q <= '0;
      par_en_lat_q <= 1'b0;
      par_flag_q <= 1'b0;
      stop_flag_q <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_cnt_q <= edge_cnt_d;
      shreg_q <= shreg_d;
      data_out_q <= data_out_d;
      par_en_lat_q <= par_en_lat_d;
      par_flag_q <= par_flag_d;
      stop_flag_q <= stop_flag_d;
      data_valid_q <= data_valid_d;
      par_err_q <= par_err_d;
      stop_err_q <= stop_err_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized and directed self-checking bench for uart_rx_ctrl against a frame-level reference model
module tb_uart_rx_ctrl;
  localparam int P = 8;
  localparam int MAPN = 16384;
  typedef struct {int cyc; logic [7:0] data; logic valid; logic perr; logic serr;} frame_t;
  logic clk = 1'b0, rst = 1'b1, rx_in = 1'b1, par_en = 1'b0, par_typ = 1'b0;
  logic [3:0] bit_count = 4'd0;
  logic bit_cnt_en, edge_done, par_en_lat, data_valid, par_err, stop_err, busy;
  logic [7:0] data_out;
  int checks = 0, fails = 0, cyc = 0, idle_edge = 0;
  int n_frames = 0, n_valid = 0, n_perr = 0, n_serr = 0, last_pulse_cyc = 0;
  logic [7:0] last_good = 8'h00;
  bit mon_on = 1'b0;
  bit busy_map [MAPN];
  bit en_map [MAPN];
  bit edge_map [MAPN];
  bit pel_map [MAPN];
  frame_t exp_q [$];
  frame_t mf;
`ifdef UART_RX_PAR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  uart_rx_ctrl #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
    .bit_count(bit_count), .bit_cnt_en(bit_cnt_en), .edge_done(edge_done),
    .par_en_lat(par_en_lat), .data_out(data_out), .data_valid(data_valid),
    .par_err(par_err), .stop_err(stop_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (rst) bit_count <= 4'd0;
    else if (bit_cnt_en && edge_done) bit_count <= (bit_count == (par_en_lat ? 4'd10 : 4'd9)) ? 4'd0 : bit_count + 4'd1;
  end
  always @(negedge clk) begin
    if (mon_on && cyc < MAPN) begin
      checks++;
      if (busy !== busy_map[cyc]) begin fails++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, busy_map[cyc]); end
      checks++;
      if (bit_cnt_en !== en_map[cyc]) begin fails++; $display("FAIL bit_cnt_en cyc=%0d got=%b exp=%b", cyc, bit_cnt_en, en_map[cyc]); end
      checks++;
      if (edge_done !== edge_map[cyc]) begin fails++; $display("FAIL edge_done cyc=%0d got=%b exp=%b", cyc, edge_done, edge_map[cyc]); end
      if (busy_map[cyc]) begin
        checks++;
        if (par_en_lat !== pel_map[cyc]) begin fails++; $display("FAIL par_en_lat cyc=%0d got=%b exp=%b", cyc, par_en_lat, pel_map[cyc]); end
      end
      if (data_valid || par_err || stop_err) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse cyc=%0d got v/p/s=%b%b%b exp none", cyc, data_valid, par_err, stop_err);
        end else begin
          mf = exp_q.pop_front();
          n_frames++;
          last_pulse_cyc = cyc;
          if (data_valid) n_valid++;
          if (par_err) n_perr++;
          if (stop_err) n_serr++;
          if (cyc !== mf.cyc) begin fails++; $display("FAIL latency got cyc=%0d exp cyc=%0d", cyc, mf.cyc); end
          checks++;
          if ({data_valid, par_err, stop_err} !== {mf.valid, mf.perr, mf.serr}) begin
            fails++;
            $display("FAIL flags cyc=%0d got v/p/s=%b%b%b exp=%b%b%b", cyc, data_valid, par_err, stop_err, mf.valid, mf.perr, mf.serr);
          end
          if (mf.valid) last_good = mf.data;
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
        checks++;
        fails++;
        $display("FAIL missing_pulse cyc=%0d got none exp frame data=%h", cyc, exp_q[0].data);
        void'(exp_q.pop_front());
      end
      checks++;
      if (data_out !== last_good) begin fails++; $display("FAIL data_out cyc=%0d got=%h exp=%h", cyc, data_out, last_good); end
    end
  end
  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt, input logic bad_par, input logic sbit, input int abort_at);
    logic bits [$];
    int c, e0, len;
    frame_t f;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(^d ^ pt ^ bad_par);
    bits.push_back(sbit);
    len = bits.size() * P;
    c = cyc;
    e0 = (c + 1 > idle_edge) ? c + 1 : idle_edge;
    for (int k = 0; k < len; k++) begin
      if (e0 + k < MAPN) begin
        busy_map[e0 + k] = 1'b1;
        en_map[e0 + k] = k < len - 1;
        edge_map[e0 + k] = (k % P) == P - 2;
        pel_map[e0 + k] = pe;
      end
    end
    f.cyc = e0 + len;
    f.data = d;
    f.serr = !sbit;
    f.perr = CHK && pe && bad_par;
    f.valid = !f.perr && !f.serr;
    exp_q.push_back(f);
    idle_edge = e0 + len + 1;
    par_en = pe;
    par_typ = pt;
    for (int k = 0; k < len; k++) begin
      if (abort_at > 0 && k == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_in = 1'b1;
        for (int i = cyc; i < MAPN; i++) begin busy_map[i] = 0; en_map[i] = 0; edge_map[i] = 0; end
        void'(exp_q.pop_back());
        last_good = 8'h00;
        idle_edge = cyc + 1;
        return;
      end
      rx_in = bits[k / P];
      if (k == P) par_en = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
  endtask
  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin @(posedge clk); #1; end
    checks++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL %s_timeout got pending=%0d exp 0", name, exp_q.size()); exp_q.delete(); end
    idle(2);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_edge = cyc + 1;
    checks += 9;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (bit_cnt_en !== 1'b0) begin fails++; $display("FAIL reset_bit_cnt_en got=%b exp=0", bit_cnt_en); end
    if (edge_done !== 1'b0) begin fails++; $display("FAIL reset_edge_done got=%b exp=0", edge_done); end
    if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    if (par_err !== 1'b0) begin fails++; $display("FAIL reset_par_err got=%b exp=0", par_err); end
    if (stop_err !== 1'b0) begin fails++; $display("FAIL reset_stop_err got=%b exp=0", stop_err); end
    if (par_en_lat !== 1'b0) begin fails++; $display("FAIL reset_par_en_lat got=%b exp=0", par_en_lat); end
    if (bit_count !== 4'd0) begin fails++; $display("FAIL reset_bit_count got=%0d exp=0", bit_count); end
    mon_on = 1'b1;
  endtask
  task automatic test_basic;
    int c, v0;
    idle(4);
    v0 = n_valid;
    c = cyc;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_drain("basic");
    checks += 3;
    if (n_valid !== v0 + 1) begin fails++; $display("FAIL basic_valid_count got=%0d exp=%0d", n_valid - v0, 1); end
    if (data_out !== 8'hA5) begin fails++; $display("FAIL basic_data got=%h exp=a5", data_out); end
    if (last_pulse_cyc !== c + 1 + 10 * P) begin fails++; $display("FAIL basic_latency got=%0d exp=%0d", last_pulse_cyc - c - 1, 10 * P); end
  endtask
  task automatic test_parity;
    int c, v0, p0;
    idle(3);
    v0 = n_valid;
    c = cyc;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    wait_drain("parity_ok");
    checks += 3;
    if (n_valid !== v0 + 1) begin fails++; $display("FAIL parity_ok_valid got=%0d exp=1", n_valid - v0); end
    if (data_out !== 8'h3C) begin fails++; $display("FAIL parity_ok_data got=%h exp=3c", data_out); end
    if (last_pulse_cyc !== c + 1 + 11 * P) begin fails++; $display("FAIL parity_latency got=%0d exp=%0d", last_pulse_cyc - c - 1, 11 * P); end
    v0 = n_valid;
    p0 = n_perr;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    wait_drain("parity_bad");
    checks += 2;
    if (n_perr - p0 !== int'(CHK)) begin fails++; $display("FAIL parity_bad_perr got=%0d exp=%0d", n_perr - p0, CHK); end
    if (n_valid - v0 !== int'(!CHK)) begin fails++; $display("FAIL parity_bad_valid got=%0d exp=%0d", n_valid - v0, !CHK); end
  endtask
  task automatic test_stop_err;
    int v0, s0;
    idle(3);
    v0 = n_valid;
    s0 = n_serr;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    wait_drain("stop_err");
    checks += 3;
    if (n_serr !== s0 + 1) begin fails++; $display("FAIL stop_err_count got=%0d exp=1", n_serr - s0); end
    if (n_valid !== v0) begin fails++; $display("FAIL stop_err_valid got=%0d exp=0", n_valid - v0); end
    if (data_out !== 8'h3C) begin fails++; $display("FAIL stop_err_data_held got=%h exp=3c", data_out); end
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_drain("after_stop_err");
    checks++;
    if (data_out !== 8'h0F) begin fails++; $display("FAIL after_stop_err_data got=%h exp=0f", data_out); end
  endtask
  task automatic test_glitch;
    int e0, f0;
    idle(4);
    e0 = cyc + 1;
    for (int k = 0; k < P / 2; k++) begin busy_map[e0 + k] = 1'b1; en_map[e0 + k] = 1'b1; pel_map[e0 + k] = par_en; end
    idle_edge = e0 + P / 2 + 1;
    f0 = n_frames;
    rx_in = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    idle(2 * P);
    checks += 4;
    if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy got=%b exp=0", busy); end
    if (bit_cnt_en !== 1'b0) begin fails++; $display("FAIL glitch_bit_cnt_en got=%b exp=0", bit_cnt_en); end
    if (bit_count !== 4'd0) begin fails++; $display("FAIL glitch_bit_count got=%0d exp=0", bit_count); end
    if (n_frames !== f0) begin fails++; $display("FAIL glitch_pulses got=%0d exp=0", n_frames - f0); end
  endtask
  task automatic test_reset_mid;
    idle(3);
    send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 5 * P + 3);
    checks += 6;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    if (bit_cnt_en !== 1'b0) begin fails++; $display("FAIL rst_mid_bit_cnt_en got=%b exp=0", bit_cnt_en); end
    if (data_out !== 8'h00) begin fails++; $display("FAIL rst_mid_data_out got=%h exp=00", data_out); end
    if ({data_valid, par_err, stop_err} !== 3'b000) begin fails++; $display("FAIL rst_mid_pulses got=%b%b%b exp=000", data_valid, par_err, stop_err); end
    if (par_en_lat !== 1'b0) begin fails++; $display("FAIL rst_mid_par_en_lat got=%b exp=0", par_en_lat); end
    if (bit_count !== 4'd0) begin fails++; $display("FAIL rst_mid_bit_count got=%0d exp=0", bit_count); end
    idle(3);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_drain("rst_mid_next");
    checks++;
    if (data_out !== 8'hC3) begin fails++; $display("FAIL rst_mid_next_data got=%h exp=c3", data_out); end
  endtask
  task automatic test_no_check;
    int p0, v0;
    idle(3);
    p0 = n_perr;
    v0 = n_valid;
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    wait_drain("no_check");
    checks += 3;
    if (n_perr - p0 !== int'(CHK)) begin fails++; $display("FAIL no_check_perr got=%0d exp=%0d", n_perr - p0, CHK); end
    if (n_valid - v0 !== int'(!CHK)) begin fails++; $display("FAIL no_check_valid got=%0d exp=%0d", n_valid - v0, !CHK); end
    if (data_out !== (CHK ? 8'hC3 : 8'h81)) begin fails++; $display("FAIL no_check_data got=%h exp=%h", data_out, CHK ? 8'hC3 : 8'h81); end
  endtask
  task automatic test_back_to_back;
    int v0;
    idle(3);
    v0 = n_valid;
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'h34, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    send_frame(8'h56, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    wait_drain("back_to_back");
    checks += 2;
    if (n_valid !== v0 + 3) begin fails++; $display("FAIL b2b_valid got=%0d exp=3", n_valid - v0); end
    if (data_out !== 8'h56) begin fails++; $display("FAIL b2b_data got=%h exp=56", data_out); end
  endtask
  task automatic test_random;
    int f0;
    f0 = n_frames;
    for (int i = 0; i < 30; i++) begin
      idle($urandom_range(5, 1));
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), ($urandom % 4) == 0, ($urandom % 8) != 0, 0);
    end
    wait_drain("random");
    checks++;
    if (n_frames !== f0 + 30) begin fails++; $display("FAIL random_frames got=%0d exp=30", n_frames - f0); end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_stop_err;
    test_glitch;
    test_reset_mid;
    test_no_check;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
